// File: rtl/weight_dispatcher.sv
// Streams num_rows weight-buffer rows to a ready/valid consumer through a credit-managed FIFO.
// Optional stall counter enabled by defining WEIGHT_DISP_PERF_EN.
module weight_dispatcher #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 4096,
   parameter int RD_LAT     = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_rows,
   output logic              busy,
   output logic              done,
   output logic              out_disp_req,
   output logic [ADDR_W-1:0] out_disp_addr,
   input  logic [DATA_W-1:0] in_disp_rdata,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [31:0]       perf_stall_cycles
);

   localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [ADDR_W:0] ONE_ROW = (ADDR_W+1)'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     reqs_left;
   logic [ADDR_W:0]     out_left;
   logic [RD_LAT-1:0]   vld_sr;
   logic [CW-1:0]       in_flight;
   logic [CW-1:0]       fifo_count;
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic                push, pop, credit_ok, accept;

   assign accept   = (state_q == IDLE) && start;
   assign push     = vld_sr[RD_LAT-1];
   assign m_valid  = (fifo_count != '0);
   assign pop      = m_valid && m_ready;
   assign m_data   = mem[rd_ptr];
   assign m_last   = m_valid && (out_left == ONE_ROW);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FIN);
   assign out_disp_addr = addr_q;

   // A row leaving this cycle frees its slot, which keeps one request per cycle in steady state.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(vld_sr[i]);
      credit_ok = (in_flight + fifo_count - CW'(pop)) < CW'(FIFO_DEPTH);
   end

   // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      out_disp_req = 1'b0;
      case (state_q)
         IDLE:  if (start) state_d = (num_rows == '0) ? FIN : ISSUE;
         ISSUE: if (credit_ok) begin
                   out_disp_req = 1'b1;
                   if (reqs_left == ONE_ROW) state_d = DRAIN;
                end
         DRAIN: if (vld_sr == '0 && fifo_count == '0 && out_left == '0) state_d = FIN;
         FIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         reqs_left  <= '0;
         out_left   <= '0;
         vld_sr     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         state_q <= state_d;
         vld_sr  <= RD_LAT'({vld_sr, out_disp_req});
         if (accept) begin
            addr_q    <= base_addr;
            reqs_left <= num_rows;
            out_left  <= num_rows;
         end
         if (out_disp_req) begin
            addr_q    <= addr_q + ADDR_W'(1);
            reqs_left <= reqs_left - ONE_ROW;
         end
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) begin
            rd_ptr   <= ptr_inc(rd_ptr);
            out_left <= out_left - ONE_ROW;
         end
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   // NOTE: row storage has no reset; cleared pointers and count make stale contents unreachable.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_disp_rdata;
   end

`ifdef WEIGHT_DISP_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst || accept)                            stall_q <= '0;
      else if (m_valid && !m_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
   end

   assign perf_stall_cycles = stall_q;
`else
   assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_weight_dispatcher.sv
// Directed self-checking bench for weight_dispatcher with a fixed-latency weight-buffer model.
module tb_weight_dispatcher;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 16;
   localparam int RD_LAT     = 3;
   localparam int FIFO_DEPTH = 4;
`ifdef WEIGHT_DISP_PERF_EN
   localparam int EXP_STALL = 5;
`else
   localparam int EXP_STALL = 0;
`endif

   logic              clk = 1'b0;
   logic              rst, start, m_ready;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W:0]   num_rows;
   logic              busy, done, out_disp_req, m_valid, m_last;
   logic [ADDR_W-1:0] out_disp_addr;
   logic [DATA_W-1:0] in_disp_rdata, m_data;
   logic [31:0]       perf_stall_cycles;

   int checks = 0;
   int errors = 0;

   weight_dispatcher #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
      .busy(busy), .done(done), .out_disp_req(out_disp_req), .out_disp_addr(out_disp_addr),
      .in_disp_rdata(in_disp_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_last(m_last), .perf_stall_cycles(perf_stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      return {~a, a};
   endfunction

   // Weight buffer: data for a request appears RD_LAT cycles later, zero otherwise.
   logic [RD_LAT-1:0] pv = '0;
   logic [ADDR_W-1:0] pa [RD_LAT];
   always @(posedge clk) begin
      pv    <= {pv[RD_LAT-2:0], out_disp_req};
      pa[0] <= out_disp_addr;
      for (int i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
   end
   assign in_disp_rdata = pv[RD_LAT-1] ? row_of(pa[RD_LAT-1]) : '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor sampled mid-cycle, away from the rising edge.
   int                cyc = 0;
   int                done_cnt = 0;
   logic [ADDR_W-1:0] req_addr_q[$];
   int                req_cyc_q[$];
   logic [DATA_W-1:0] row_q[$];
   logic              last_q[$];
   int                pop_cyc_q[$];
   logic              hold = 1'b0;
   logic [DATA_W-1:0] held_data;

   always @(negedge clk) begin
      cyc++;
      if (out_disp_req) begin
         req_addr_q.push_back(out_disp_addr);
         req_cyc_q.push_back(cyc);
      end
      if (m_valid && m_ready) begin
         row_q.push_back(m_data);
         last_q.push_back(m_last);
         pop_cyc_q.push_back(cyc);
      end
      if (done) done_cnt++;
      if (hold && m_valid) check("m_data_stable", 64'(m_data), 64'(held_data));
      hold      = m_valid && !m_ready;
      held_data = m_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      req_addr_q.delete();
      req_cyc_q.delete();
      row_q.delete();
      last_q.delete();
      pop_cyc_q.delete();
      done_cnt = 0;
   endtask

   task automatic launch(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] n);
      start     = 1'b1;
      base_addr = base;
      num_rows  = n;
      tick();
      start     = 1'b0;
      base_addr = 8'hAA;
      num_rows  = 9'd7;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
   endtask

   task automatic check_rows(input string tag, input logic [ADDR_W-1:0] base, input int n);
      logic [ADDR_W-1:0] a;
      check({tag, "_req_count"}, 64'(req_addr_q.size()), 64'(n));
      check({tag, "_row_count"}, 64'(row_q.size()), 64'(n));
      if (req_addr_q.size() == n && row_q.size() == n) begin
         for (int i = 0; i < n; i++) begin
            a = base + ADDR_W'(i);
            check($sformatf("%s_addr%0d", tag, i), 64'(req_addr_q[i]), 64'(a));
            check($sformatf("%s_row%0d", tag, i), 64'(row_q[i]), 64'(row_of(a)));
            check($sformatf("%s_last%0d", tag, i), 64'(last_q[i]), 64'(i == n - 1));
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int k;
      rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; m_ready = 1'b0;
      tick(); tick();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_req", 64'(out_disp_req), 64'd0);
      check("rst_addr", 64'(out_disp_addr), 64'd0);
      check("rst_valid", 64'(m_valid), 64'd0);
      check("rst_last", 64'(m_last), 64'd0);
      check("rst_perf", 64'(perf_stall_cycles), 64'd0);
      rst = 1'b0;
      tick();

      // Basic 4-row transfer; a second start while busy must be ignored.
      clear_mon(); m_ready = 1'b1;
      launch(8'h10, 9'd4);
      check("t1_busy", 64'(busy), 64'd1);
      tick(); start = 1'b1; base_addr = 8'h55; num_rows = 9'd3; tick(); start = 1'b0;
      wait_done("t1", 40);
      check_rows("t1", 8'h10, 4);
      if (req_cyc_q.size() == 4) check("t1_req_span", 64'(req_cyc_q[3] - req_cyc_q[0]), 64'd3);
      check("t1_idle", 64'(busy), 64'd0);

      // Address wrap.
      clear_mon();
      launch(8'hFE, 9'd4);
      wait_done("t2", 40);
      check_rows("t2", 8'hFE, 4);

      // Downstream stalled for 20 cycles: credit limits requests to FIFO_DEPTH.
      clear_mon(); m_ready = 1'b0;
      launch(8'h40, 9'd16);
      repeat (20) tick();
      m_ready = 1'b1;
      wait_done("t3", 120);
      k = 0;
      foreach (req_cyc_q[i]) if (pop_cyc_q.size() == 0 || req_cyc_q[i] < pop_cyc_q[0]) k++;
      check("t3_reqs_before_pop", 64'(k), 64'(FIFO_DEPTH));
      check_rows("t3", 8'h40, 16);

      // Full throughput: one request and one row per cycle.
      clear_mon();
      launch(8'h80, 9'd8);
      wait_done("t4", 60);
      check_rows("t4", 8'h80, 8);
      if (req_cyc_q.size() == 8) check("t4_req_span", 64'(req_cyc_q[7] - req_cyc_q[0]), 64'd7);
      if (pop_cyc_q.size() == 8) check("t4_pop_span", 64'(pop_cyc_q[7] - pop_cyc_q[0]), 64'd7);

      // Zero rows: straight to the done pulse, no requests.
      clear_mon();
      launch(8'h77, 9'd0);
      check("t5_done", 64'(done), 64'd1);
      check("t5_busy", 64'(busy), 64'd1);
      tick();
      check("t5_done_low", 64'(done), 64'd0);
      check("t5_busy_low", 64'(busy), 64'd0);
      repeat (2) tick();
      check("t5_reqs", 64'(req_addr_q.size()), 64'd0);
      check("t5_done_count", 64'(done_cnt), 64'd1);

      // Reset two cycles into a transfer aborts it; the next transfer runs normally.
      clear_mon();
      launch(8'h20, 9'd8);
      tick(); tick();
      rst = 1'b1;
      tick();
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_req", 64'(out_disp_req), 64'd0);
      check("t6_valid", 64'(m_valid), 64'd0);
      check("t6_addr", 64'(out_disp_addr), 64'd0);
      check("t6_done", 64'(done), 64'd0);
      rst = 1'b0;
      repeat (10) tick();
      check("t6_no_done", 64'(done_cnt), 64'd0);
      clear_mon();
      launch(8'h30, 9'd2);
      wait_done("t6b", 40);
      check_rows("t6b", 8'h30, 2);

      // Five stalled cycles with a row waiting.
      clear_mon(); m_ready = 1'b0;
      launch(8'h50, 9'd2);
      k = 0;
      while (!m_valid && k < 20) begin
         tick();
         k++;
      end
      check("t7_valid_seen", 64'(m_valid), 64'd1);
      repeat (5) tick();
      m_ready = 1'b1;
      wait_done("t7", 40);
      check_rows("t7", 8'h50, 2);
      check("t7_perf", 64'(perf_stall_cycles), 64'(EXP_STALL));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
